nn_reset_sequencer: RTL and testbench
=====================================

// Module: nn_reset_sequencer
// PURPOSE
//  Multi-channel reset sequencer; parametrised successor to the single-output power-on reset source.
//  Holds NUM_CHANNELS active-high reset outputs asserted until the clock source reports lock.
//  Requires INITIAL_RESET_CYCLES consecutive locked cycles, then releases channels 0..N-1 one at a
//  time, STAGE_CYCLES apart. Sits beside the clock divider; feeds memory controller, cache, display.
// PARAMETERS
//  NUM_CHANNELS          4   number of reset outputs (>=1); channel 0 released first
//  INITIAL_RESET_CYCLES  30  consecutive locked cycles before channel 0 release (>=1)
//  STAGE_CYCLES          8   cycles between successive channel releases (>=1)
//  CNT_WIDTH             16  internal counter width; must hold max(INITIAL_RESET_CYCLES, STAGE_CYCLES)
// PORTS
//  clk              in   1             single clock; all logic on rising edge
//  reset            in   1             synchronous, active-high
//  locked           in   1             clock source stable (synchronous to clk)
//  soft_reset_req   in   1             request full re-sequence; level-sampled each edge
//  reset_out        out  NUM_CHANNELS  per-channel reset, active-high
//  reset_done       out  1             all channels released
//  seq_count        out  8             completed sequences; saturating
// BEHAVIOUR
//  Reset (reset=1 at an edge): state=ASSERT, cnt=0, stage=0, reset_out=all 1s, reset_done=0,
//   seq_count=0. Reset has priority over every other input.
//  Abort: locked=0 or soft_reset_req=1 at an edge (reset=0) -> next state ASSERT, cnt=0, stage=0,
//   reset_out=all 1s, reset_done=0; seq_count holds. Same action in every state and for both causes.
//   A held request or held !locked keeps the block in ASSERT with cnt=0.
//  ASSERT: each edge with locked=1, req=0: cnt++. At the edge where cnt==INITIAL_RESET_CYCLES-1:
//   reset_out[0]<=0, cnt<=0, stage<=1. Next state is STAGGER, or DONE if NUM_CHANNELS==1.
//  STAGGER: cnt++ each edge. At the edge where cnt==STAGE_CYCLES-1: reset_out[stage]<=0, cnt<=0,
//   stage++. On release of channel NUM_CHANNELS-1 -> DONE; on that same edge reset_done<=1 and
//   seq_count<=seq_count+1 (held at 255 once reached).
//  DONE: outputs stable until abort or reset.
//  Latency (locked=1, req=0 throughout): reset_out[i] falls exactly INITIAL_RESET_CYCLES+i*STAGE_CYCLES
//   rising edges after the first edge sampling reset=0. reset_done rises with reset_out[N-1].
//  Invariant: released channels always form a prefix 0..k. Once low, reset_out[i] changes only via
//   abort or reset. reset_out and reset_done are registered; there is no combinational path from
//   input to output.
//  Reset or abort mid-operation: all channels reasserted on the next edge. Count and stage restart from
//   0; no partial resume.
// TESTING (NUM_CHANNELS=4, INITIAL_RESET_CYCLES=30, STAGE_CYCLES=8)
//  1 locked=1, reset high 2 cycles then low -> reset_out[0..3] fall at edges 30/38/46/54 after release;
//    reset_done=1 at edge 54; seq_count=1.
//  2 locked=0 for 100 cycles after reset -> reset_out=4'hF throughout; locked rises -> reset_out[0]
//    falls 30 edges after the first edge sampling locked=1.
//  3 In DONE, 1-cycle soft_reset_req -> next edge reset_out=4'hF, reset_done=0; full re-sequence
//    repeats 30/38/46/54 timing; seq_count=2.
//  4 locked drops 1 cycle just after reset_out[1] falls -> next edge reset_out=4'hF; sequence restarts;
//    channel 0 released 30 edges after locked is sampled high again.
//  5 reset pulsed during STAGGER with seq_count=3 -> next edge reset_out=4'hF, reset_done=0,
//    seq_count=0.
//  6 300 soft-request/complete cycles -> seq_count saturates at 255, no wrap; soft_reset_req held
//    high -> reset_out stays 4'hF.

Source files
------------

// File: rtl/nn_reset_sequencer_if.sv
// Purpose : bundles the lock/request inputs and the reset outputs of the reset sequencer.
// Ports   : locked, soft_reset_req (towards sequencer); reset_out, reset_done, seq_count (from it).
// master  : the sequencer itself; slave: clock source / reset consumers / request logic.
interface nn_reset_sequencer_if #(
  parameter int NUM_CHANNELS = 4
);
  logic                    locked;
  logic                    soft_reset_req;
  logic [NUM_CHANNELS-1:0] reset_out;
  logic                    reset_done;
  logic [7:0]              seq_count;

  modport master (
    input  locked,
    input  soft_reset_req,
    output reset_out,
    output reset_done,
    output seq_count
  );

  modport slave (
    output locked,
    output soft_reset_req,
    input  reset_out,
    input  reset_done,
    input  seq_count
  );
endinterface

// File: rtl/nn_reset_sequencer.sv
// Purpose : multi-channel reset sequencer; holds all channel resets until the clock is locked for
//           INITIAL_RESET_CYCLES, then releases channels 0..N-1 one by one, STAGE_CYCLES apart.
// Latency : channel i released INITIAL_RESET_CYCLES + i*STAGE_CYCLES edges after reset/abort clears;
//           all outputs are registered. No backpressure: outputs are levels, inputs are sampled each edge.
// Ports   : clk, reset (sync, active-high); rst_if.master carries locked, soft_reset_req (in) and
//           reset_out, reset_done, seq_count (out).
module nn_reset_sequencer #(
  parameter int NUM_CHANNELS         = 4,
  parameter int INITIAL_RESET_CYCLES = 30,
  parameter int STAGE_CYCLES         = 8,
  parameter int CNT_WIDTH            = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  nn_reset_sequencer_if.master rst_if
);

  // Stage index must be able to hold NUM_CHANNELS (one past the last channel).
  localparam int STAGE_W = $clog2(NUM_CHANNELS + 1);

  localparam logic [CNT_WIDTH-1:0] INIT_LAST  = CNT_WIDTH'(INITIAL_RESET_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] STAGE_LAST = CNT_WIDTH'(STAGE_CYCLES - 1);
  localparam logic [STAGE_W-1:0]   LAST_CH    = STAGE_W'(NUM_CHANNELS - 1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_STAGGER = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t                  state_q,      state_d;
  logic [CNT_WIDTH-1:0]    cnt_q,        cnt_d;
  logic [STAGE_W-1:0]      stage_q,      stage_d;
  logic [NUM_CHANNELS-1:0] reset_out_q,  reset_out_d;
  logic                    reset_done_q, reset_done_d;
  logic [7:0]              seq_count_q,  seq_count_d;

  logic abort;
  logic [7:0] seq_count_inc;

  // Loss of lock and a soft request are handled identically, whatever the state.
  assign abort = !rst_if.locked || rst_if.soft_reset_req;

  // Completed-sequence counter saturates rather than wrapping.
  assign seq_count_inc = (seq_count_q == 8'hFF) ? seq_count_q : seq_count_q + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_ASSERT;
      cnt_q        <= '0;
      stage_q      <= '0;
      reset_out_q  <= '1;
      reset_done_q <= 1'b0;
      seq_count_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      stage_q      <= stage_d;
      reset_out_q  <= reset_out_d;
      reset_done_q <= reset_done_d;
      seq_count_q  <= seq_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stage_d      = stage_q;
    reset_out_d  = reset_out_q;
    reset_done_d = reset_done_q;
    seq_count_d  = seq_count_q;

    if (abort) begin
      // Full restart, no partial resume; the completed-sequence count survives.
      state_d      = ST_ASSERT;
      cnt_d        = '0;
      stage_d      = '0;
      reset_out_d  = '1;
      reset_done_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_ASSERT: begin
          if (cnt_q == INIT_LAST) begin
            reset_out_d[0] = 1'b0;
            cnt_d          = '0;
            stage_d        = STAGE_W'(1);
            if (NUM_CHANNELS == 1) begin
              // Single channel: its release is also the end of the sequence.
              state_d      = ST_DONE;
              reset_done_d = 1'b1;
              seq_count_d  = seq_count_inc;
            end else begin
              state_d = ST_STAGGER;
            end
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end

        ST_STAGGER: begin
          if (cnt_q == STAGE_LAST) begin
            // Release exactly the channel named by stage_q, keeping the released set a prefix.
            for (int i = 0; i < NUM_CHANNELS; i++) begin
              if (stage_q == STAGE_W'(i)) begin
                reset_out_d[i] = 1'b0;
              end
            end
            cnt_d   = '0;
            stage_d = stage_q + STAGE_W'(1);
            if (stage_q == LAST_CH) begin
              state_d      = ST_DONE;
              reset_done_d = 1'b1;
              seq_count_d  = seq_count_inc;
            end
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end

        ST_DONE: begin
          // Outputs hold until an abort or reset.
        end

        default: begin
          state_d     = ST_ASSERT;
          cnt_d       = '0;
          stage_d     = '0;
          reset_out_d = '1;
          reset_done_d = 1'b0;
        end
      endcase
    end
  end

  assign rst_if.reset_out  = reset_out_q;
  assign rst_if.reset_done = reset_done_q;
  assign rst_if.seq_count  = seq_count_q;

endmodule

// File: tb/tb_nn_reset_sequencer.sv
// Purpose : self-checking bench for nn_reset_sequencer (4 channels, 30 initial, 8 per stage).
// Expected outputs come from a count of consecutive "good" edges since the last reset/abort.
// Each driven cycle pushes its expected outputs; they are popped and compared after the edge.
module tb_nn_reset_sequencer;

  localparam int NCH   = 4;
  localparam int INIT  = 30;
  localparam int STAGE = 8;
  localparam int DONE_AT = INIT + (NCH - 1) * STAGE;

  typedef struct {
    logic [NCH-1:0] rout;
    logic           done;
    logic [7:0]     seq;
  } exp_t;

  logic clk;
  logic reset;

  nn_reset_sequencer_if #(.NUM_CHANNELS(NCH)) rif ();

  nn_reset_sequencer #(
    .NUM_CHANNELS        (NCH),
    .INITIAL_RESET_CYCLES(INIT),
    .STAGE_CYCLES        (STAGE),
    .CNT_WIDTH           (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rst_if(rif.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  // Model state: consecutive good edges since last reset/abort, and completed sequences.
  int   good_cnt = 0;
  int   seq_mdl  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, predict the outputs after the next edge, then check them.
  task automatic step(input logic rst, input logic lk, input logic req);
    exp_t e;
    exp_t got;
    @(negedge clk);
    reset              = rst;
    rif.locked         = lk;
    rif.soft_reset_req = req;
    if (rst) begin
      good_cnt = 0;
      seq_mdl  = 0;
    end else if (!lk || req) begin
      good_cnt = 0;
    end else begin
      good_cnt++;
      if (good_cnt == DONE_AT && seq_mdl < 255) seq_mdl++;
    end
    for (int i = 0; i < NCH; i++) e.rout[i] = (good_cnt < INIT + i * STAGE);
    e.done = (good_cnt >= DONE_AT);
    e.seq  = 8'(seq_mdl);
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      got = exp_q.pop_front();
      chk("reset_out",  32'(rif.reset_out),  32'(got.rout));
      chk("reset_done", 32'(rif.reset_done), 32'(got.done));
      chk("seq_count",  32'(rif.seq_count),  32'(got.seq));
    end
  endtask

  task automatic run_good(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    reset              = 1'b1;
    rif.locked         = 1'b1;
    rif.soft_reset_req = 1'b0;

    // 1: reset for two cycles with lock, then a full sequence.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("rst_state_out",  32'(rif.reset_out),  32'hF);
    chk("rst_state_done", 32'(rif.reset_done), 32'd0);
    chk("rst_state_seq",  32'(rif.seq_count),  32'd0);
    run_good(INIT - 1);
    chk("t1_edge29_out", 32'(rif.reset_out), 32'hF);
    run_good(1);
    chk("t1_edge30_out", 32'(rif.reset_out), 32'hE);
    run_good(DONE_AT - INIT - 1);
    chk("t1_edge53_done", 32'(rif.reset_done), 32'd0);
    run_good(1);
    chk("t1_edge54_out",  32'(rif.reset_out),  32'h0);
    chk("t1_edge54_done", 32'(rif.reset_done), 32'd1);
    run_good(6);
    chk("t1_seq", 32'(rif.seq_count), 32'd1);

    // 3: one-cycle soft request from DONE, full re-sequence.
    step(1'b0, 1'b1, 1'b1);
    chk("t3_req_out",  32'(rif.reset_out),  32'hF);
    chk("t3_req_done", 32'(rif.reset_done), 32'd0);
    run_good(DONE_AT + 4);
    chk("t3_seq", 32'(rif.seq_count), 32'd2);

    // 4: lock drops for one cycle right after channel 1 releases.
    step(1'b0, 1'b1, 1'b1);
    run_good(INIT + STAGE);
    chk("t4_ch1_out", 32'(rif.reset_out), 32'hC);
    step(1'b0, 1'b0, 1'b0);
    chk("t4_drop_out", 32'(rif.reset_out), 32'hF);
    run_good(DONE_AT + 2);
    chk("t4_seq", 32'(rif.seq_count), 32'd3);

    // 5: reset pulse during STAGGER.
    step(1'b0, 1'b1, 1'b1);
    run_good(INIT + 5);
    chk("t5_stagger_out", 32'(rif.reset_out), 32'hE);
    step(1'b1, 1'b1, 1'b0);
    chk("t5_rst_out",  32'(rif.reset_out),  32'hF);
    chk("t5_rst_done", 32'(rif.reset_done), 32'd0);
    chk("t5_rst_seq",  32'(rif.seq_count),  32'd0);

    // 2: no lock for 100 cycles, then lock.
    for (int k = 0; k < 100; k++) step(1'b0, 1'b0, 1'b0);
    chk("t2_nolock_out", 32'(rif.reset_out), 32'hF);
    run_good(INIT);
    chk("t2_lock_out", 32'(rif.reset_out), 32'hE);
    run_good(DONE_AT - INIT + 2);

    // 6: many request/complete cycles saturate the counter.
    for (int k = 0; k < 300; k++) begin
      step(1'b0, 1'b1, 1'b1);
      run_good(DONE_AT + 1);
    end
    chk("t6_sat_seq", 32'(rif.seq_count), 32'd255);
    for (int k = 0; k < 80; k++) step(1'b0, 1'b1, 1'b1);
    chk("t6_held_out",  32'(rif.reset_out),  32'hF);
    chk("t6_held_done", 32'(rif.reset_done), 32'd0);
    chk("t6_held_seq",  32'(rif.seq_count),  32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
